// File: rtl/idct_pkg.sv
// Shared types and fixed constants for the pipelined 8x8 Chen-Wang inverse DCT.
package idct_pkg;

    typedef logic signed [15:0] coef_t;
    typedef logic signed [31:0] acc_t;
    typedef coef_t [7:0]        vec8_t;

    localparam acc_t W1   = 32'sd2841;
    localparam acc_t W2   = 32'sd2676;
    localparam acc_t W3   = 32'sd2408;
    localparam acc_t W5   = 32'sd1609;
    localparam acc_t W6   = 32'sd1108;
    localparam acc_t W7   = 32'sd565;
    localparam acc_t C181 = 32'sd181;

    localparam acc_t ROW_LOAD_RND = 32'sd128;
    localparam acc_t COL_LOAD_RND = 32'sd8192;
    localparam acc_t ROW_MUL_RND  = 32'sd0;
    localparam acc_t COL_MUL_RND  = 32'sd4;
    localparam acc_t BFLY_RND     = 32'sd128;

    localparam int unsigned ROW_LOAD_SH = 11;
    localparam int unsigned COL_LOAD_SH = 8;
    localparam int unsigned ROW_MUL_SH  = 0;
    localparam int unsigned COL_MUL_SH  = 3;
    localparam int unsigned BFLY_SH     = 8;
    localparam int unsigned ROW_OUT_SH  = 8;
    localparam int unsigned COL_OUT_SH  = 14;

    localparam acc_t CLIP_MIN = -32'sd256;
    localparam acc_t CLIP_MAX = 32'sd255;

    // Stage budget: add 1, multiply 3, compare 3; core is load..final butterfly rounding.
    localparam int unsigned MUL_STAGES  = 3;
    localparam int unsigned CMP_STAGES  = 3;
    localparam int unsigned CORE_STAGES = 11;
    localparam int unsigned ROW_LAT     = 14;
    localparam int unsigned COL_LAT     = 15;
    localparam int unsigned LATENCY     = ROW_LAT + COL_LAT;

    typedef struct packed { acc_t x0, x1, x2, x3, x4, x5, x6, x7, s23, s45, s67; } load_t;
    typedef struct packed { acc_t t45, p4, p5, t67, p6, p7, t23, p2, p3; } prod_t;
    typedef struct packed { acc_t x2, x3, x4, x5, x6, x7; } odd_t;
    typedef struct packed { acc_t x0, x1, x2, x3, x4, x5, x6, x8; } bfly_t;
    typedef struct packed { acc_t x0, x1, x3, x6, x7, x8; } keep_t;
    typedef struct packed { keep_t k; acc_t sm; acc_t df; } join_t;
    typedef struct packed { acc_t mp; acc_t mm; } rot_t;
    typedef struct packed { acc_t x0, x1, x2, x3, x4, x6, x7, x8; } fin_t;
    typedef struct packed { logic [7:0] lo; logic [7:0] hi; vec8_t v; } clip_t;

endpackage

// File: rtl/idct_1d.sv
// One 8-point Chen-Wang IDCT lane; IS_COL picks column scaling, rounding and output clip.
module idct_1d
    import idct_pkg::*;
#(
    parameter bit IS_COL = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  vec8_t b_i,
    output vec8_t y_o
);

    localparam int unsigned LOAD_SH  = IS_COL ? COL_LOAD_SH : ROW_LOAD_SH;
    localparam acc_t        LOAD_RND = IS_COL ? COL_LOAD_RND : ROW_LOAD_RND;
    localparam int unsigned MUL_SH   = IS_COL ? COL_MUL_SH : ROW_MUL_SH;
    localparam acc_t        MUL_RND  = IS_COL ? COL_MUL_RND : ROW_MUL_RND;

    load_t      ld_d, ld_q;
    prod_t      pr_d, pr_q;
    acc_t [1:0] ev_q;
    odd_t       s5_d, s5_q;
    bfly_t      s6_d, s6_q;
    join_t      s7_d, s7_q;
    rot_t       rot_d, rot_q;
    keep_t      keep_q;
    fin_t       fin_d, fin_q;
    acc_t [7:0] sum_d;

    // Load: scale the DC/4 terms and pre-add the pairs feeding each rotation.
    always_comb begin
        ld_d     = '0;
        ld_d.x0  = (acc_t'(b_i[0]) <<< LOAD_SH) + LOAD_RND;
        ld_d.x1  = acc_t'(b_i[4]) <<< LOAD_SH;
        ld_d.x2  = acc_t'(b_i[6]);
        ld_d.x3  = acc_t'(b_i[2]);
        ld_d.x4  = acc_t'(b_i[1]);
        ld_d.x5  = acc_t'(b_i[7]);
        ld_d.x6  = acc_t'(b_i[5]);
        ld_d.x7  = acc_t'(b_i[3]);
        ld_d.s23 = ld_d.x3 + ld_d.x2;
        ld_d.s45 = ld_d.x4 + ld_d.x5;
        ld_d.s67 = ld_d.x6 + ld_d.x7;
    end

    always_comb begin
        pr_d     = '0;
        pr_d.t45 = W7 * ld_q.s45;
        pr_d.p4  = (W1 - W7) * ld_q.x4;
        pr_d.p5  = (W1 + W7) * ld_q.x5;
        pr_d.t67 = W3 * ld_q.s67;
        pr_d.p6  = (W3 - W5) * ld_q.x6;
        pr_d.p7  = (W3 + W5) * ld_q.x7;
        pr_d.t23 = W6 * ld_q.s23;
        pr_d.p2  = (W2 + W6) * ld_q.x2;
        pr_d.p3  = (W2 - W6) * ld_q.x3;
    end

    idct_delay #(.W($bits(prod_t)), .N(MUL_STAGES)) u_mul_pipe (
        .clk(clk), .rst(rst), .d_i(pr_d), .q_o(pr_q)
    );

    // Even terms skip the rotations, so they wait for the multiply and combine stages.
    idct_delay #(.W(2 * $bits(acc_t)), .N(MUL_STAGES + 1)) u_even_pipe (
        .clk(clk), .rst(rst), .d_i({ld_q.x1, ld_q.x0}), .q_o(ev_q)
    );

    always_comb begin
        s5_d    = '0;
        s5_d.x4 = (pr_q.t45 + MUL_RND + pr_q.p4) >>> MUL_SH;
        s5_d.x5 = (pr_q.t45 + MUL_RND - pr_q.p5) >>> MUL_SH;
        s5_d.x6 = (pr_q.t67 + MUL_RND - pr_q.p6) >>> MUL_SH;
        s5_d.x7 = (pr_q.t67 + MUL_RND - pr_q.p7) >>> MUL_SH;
        s5_d.x2 = (pr_q.t23 + MUL_RND - pr_q.p2) >>> MUL_SH;
        s5_d.x3 = (pr_q.t23 + MUL_RND + pr_q.p3) >>> MUL_SH;
    end

    always_comb begin
        s6_d    = '0;
        s6_d.x8 = ev_q[0] + ev_q[1];
        s6_d.x0 = ev_q[0] - ev_q[1];
        s6_d.x1 = s5_q.x4 + s5_q.x6;
        s6_d.x4 = s5_q.x4 - s5_q.x6;
        s6_d.x6 = s5_q.x5 + s5_q.x7;
        s6_d.x5 = s5_q.x5 - s5_q.x7;
        s6_d.x2 = s5_q.x2;
        s6_d.x3 = s5_q.x3;
    end

    always_comb begin
        s7_d      = '0;
        s7_d.k.x7 = s6_q.x8 + s6_q.x3;
        s7_d.k.x8 = s6_q.x8 - s6_q.x3;
        s7_d.k.x3 = s6_q.x0 + s6_q.x2;
        s7_d.k.x0 = s6_q.x0 - s6_q.x2;
        s7_d.k.x1 = s6_q.x1;
        s7_d.k.x6 = s6_q.x6;
        s7_d.sm   = s6_q.x4 + s6_q.x5;
        s7_d.df   = s6_q.x4 - s6_q.x5;
    end

    always_comb begin
        rot_d    = '0;
        rot_d.mp = C181 * s7_q.sm;
        rot_d.mm = C181 * s7_q.df;
    end

    idct_delay #(.W($bits(rot_t)), .N(MUL_STAGES)) u_rot_pipe (
        .clk(clk), .rst(rst), .d_i(rot_d), .q_o(rot_q)
    );

    idct_delay #(.W($bits(keep_t)), .N(MUL_STAGES)) u_keep_pipe (
        .clk(clk), .rst(rst), .d_i(s7_q.k), .q_o(keep_q)
    );

    always_comb begin
        fin_d    = '0;
        fin_d.x2 = (rot_q.mp + BFLY_RND) >>> BFLY_SH;
        fin_d.x4 = (rot_q.mm + BFLY_RND) >>> BFLY_SH;
        fin_d.x0 = keep_q.x0;
        fin_d.x1 = keep_q.x1;
        fin_d.x3 = keep_q.x3;
        fin_d.x6 = keep_q.x6;
        fin_d.x7 = keep_q.x7;
        fin_d.x8 = keep_q.x8;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q  <= '0;
            s5_q  <= '0;
            s6_q  <= '0;
            s7_q  <= '0;
            fin_q <= '0;
        end else begin
            ld_q  <= ld_d;
            s5_q  <= s5_d;
            s6_q  <= s6_d;
            s7_q  <= s7_d;
            fin_q <= fin_d;
        end
    end

    always_comb begin
        sum_d    = '0;
        sum_d[0] = fin_q.x7 + fin_q.x1;
        sum_d[1] = fin_q.x3 + fin_q.x2;
        sum_d[2] = fin_q.x0 + fin_q.x4;
        sum_d[3] = fin_q.x8 + fin_q.x6;
        sum_d[4] = fin_q.x8 - fin_q.x6;
        sum_d[5] = fin_q.x0 - fin_q.x4;
        sum_d[6] = fin_q.x3 - fin_q.x2;
        sum_d[7] = fin_q.x7 - fin_q.x1;
    end

    if (IS_COL) begin : g_col
        acc_t [7:0] v_q;
        clip_t      cmp_d, cmp_q;
        vec8_t      y_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= '0;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    v_q[k] <= sum_d[k] >>> COL_OUT_SH;
                end
            end
        end

        always_comb begin
            cmp_d = '0;
            for (int k = 0; k < 8; k++) begin
                cmp_d.lo[k] = v_q[k] < CLIP_MIN;
                cmp_d.hi[k] = v_q[k] > CLIP_MAX;
                cmp_d.v[k]  = coef_t'(v_q[k]);
            end
        end

        idct_delay #(.W($bits(clip_t)), .N(CMP_STAGES - 1)) u_cmp_pipe (
            .clk(clk), .rst(rst), .d_i(cmp_d), .q_o(cmp_q)
        );

        // Low-order bits are only used when neither clip flag is set.
        always_ff @(posedge clk) begin
            if (rst) begin
                y_q <= '0;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    y_q[k] <= cmp_q.lo[k] ? coef_t'(CLIP_MIN)
                            : (cmp_q.hi[k] ? coef_t'(CLIP_MAX) : cmp_q.v[k]);
                end
            end
        end

        assign y_o = y_q;
    end else begin : g_row
        vec8_t y_d;

        always_comb begin
            y_d = '0;
            for (int k = 0; k < 8; k++) begin
                y_d[k] = coef_t'(sum_d[k] >>> ROW_OUT_SH);
            end
        end

        // Output register plus padding so row and column lanes split the latency 14/15.
        idct_delay #(.W($bits(vec8_t)), .N(ROW_LAT - CORE_STAGES)) u_row_pad (
            .clk(clk), .rst(rst), .d_i(y_d), .q_o(y_o)
        );
    end

endmodule

// File: rtl/idct_delay.sv
// Resettable N-stage register chain used to delay-balance parallel datapath branches.
module idct_delay #(
    parameter int unsigned W = 1,
    parameter int unsigned N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [N-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int unsigned i = 1; i < N; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[N-1];

endmodule

// File: rtl/idct.sv
// Fully pipelined 8x8 inverse DCT: eight row lanes, transpose, eight column lanes.
module idct
    import idct_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic signed [15:0] x0, x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, x11, x12, x13, x14, x15,
    input  logic signed [15:0] x16, x17, x18, x19, x20, x21, x22, x23, x24, x25, x26, x27, x28, x29, x30, x31,
    input  logic signed [15:0] x32, x33, x34, x35, x36, x37, x38, x39, x40, x41, x42, x43, x44, x45, x46, x47,
    input  logic signed [15:0] x48, x49, x50, x51, x52, x53, x54, x55, x56, x57, x58, x59, x60, x61, x62, x63,
    output logic signed [15:0] out0, out1, out2, out3, out4, out5, out6, out7, out8, out9, out10, out11, out12, out13, out14, out15,
    output logic signed [15:0] out16, out17, out18, out19, out20, out21, out22, out23, out24, out25, out26, out27, out28, out29, out30, out31,
    output logic signed [15:0] out32, out33, out34, out35, out36, out37, out38, out39, out40, out41, out42, out43, out44, out45, out46, out47,
    output logic signed [15:0] out48, out49, out50, out51, out52, out53, out54, out55, out56, out57, out58, out59, out60, out61, out62, out63
);

    logic [63:0][15:0] xp;
    logic [63:0][15:0] op;
    vec8_t row_in  [8];
    vec8_t row_out [8];
    vec8_t col_in  [8];
    vec8_t col_out [8];

    assign xp = {x63, x62, x61, x60, x59, x58, x57, x56, x55, x54, x53, x52, x51, x50, x49, x48,
                 x47, x46, x45, x44, x43, x42, x41, x40, x39, x38, x37, x36, x35, x34, x33, x32,
                 x31, x30, x29, x28, x27, x26, x25, x24, x23, x22, x21, x20, x19, x18, x17, x16,
                 x15, x14, x13, x12, x11, x10, x9, x8, x7, x6, x5, x4, x3, x2, x1, x0};

    assign {out63, out62, out61, out60, out59, out58, out57, out56, out55, out54, out53, out52, out51, out50, out49, out48,
            out47, out46, out45, out44, out43, out42, out41, out40, out39, out38, out37, out36, out35, out34, out33, out32,
            out31, out30, out29, out28, out27, out26, out25, out24, out23, out22, out21, out20, out19, out18, out17, out16,
            out15, out14, out13, out12, out11, out10, out9, out8, out7, out6, out5, out4, out3, out2, out1, out0} = op;

    always_comb begin
        row_in = '{default: '0};
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                row_in[r][c] = coef_t'(xp[8*r+c]);
            end
        end
    end

    // Transpose between passes: column lane c takes element c of every row result.
    always_comb begin
        col_in = '{default: '0};
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                col_in[c][r] = row_out[r][c];
            end
        end
    end

    always_comb begin
        op = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                op[8*r+c] = col_out[c][r];
            end
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_lane
        idct_1d #(.IS_COL(1'b0)) u_row (
            .clk(clk), .rst(rst), .b_i(row_in[i]), .y_o(row_out[i])
        );
        idct_1d #(.IS_COL(1'b1)) u_col (
            .clk(clk), .rst(rst), .b_i(col_in[i]), .y_o(col_out[i])
        );
    end

endmodule

// File: tb/tb_idct.sv
// Directed-vector bench for the 8x8 IDCT: reset, DC, ramp, clipping, streaming, mid-stream reset.
module tb_idct;

    logic clk = 1'b0;
    logic rst;
    logic signed [15:0] x [64];
    logic signed [15:0] o [64];
    int checks = 0;
    int errors = 0;

    idct dut (
        .clk(clk), .rst(rst),
        .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]), .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
        .x8(x[8]), .x9(x[9]), .x10(x[10]), .x11(x[11]), .x12(x[12]), .x13(x[13]), .x14(x[14]), .x15(x[15]),
        .x16(x[16]), .x17(x[17]), .x18(x[18]), .x19(x[19]), .x20(x[20]), .x21(x[21]), .x22(x[22]), .x23(x[23]),
        .x24(x[24]), .x25(x[25]), .x26(x[26]), .x27(x[27]), .x28(x[28]), .x29(x[29]), .x30(x[30]), .x31(x[31]),
        .x32(x[32]), .x33(x[33]), .x34(x[34]), .x35(x[35]), .x36(x[36]), .x37(x[37]), .x38(x[38]), .x39(x[39]),
        .x40(x[40]), .x41(x[41]), .x42(x[42]), .x43(x[43]), .x44(x[44]), .x45(x[45]), .x46(x[46]), .x47(x[47]),
        .x48(x[48]), .x49(x[49]), .x50(x[50]), .x51(x[51]), .x52(x[52]), .x53(x[53]), .x54(x[54]), .x55(x[55]),
        .x56(x[56]), .x57(x[57]), .x58(x[58]), .x59(x[59]), .x60(x[60]), .x61(x[61]), .x62(x[62]), .x63(x[63]),
        .out0(o[0]), .out1(o[1]), .out2(o[2]), .out3(o[3]), .out4(o[4]), .out5(o[5]), .out6(o[6]), .out7(o[7]),
        .out8(o[8]), .out9(o[9]), .out10(o[10]), .out11(o[11]), .out12(o[12]), .out13(o[13]), .out14(o[14]), .out15(o[15]),
        .out16(o[16]), .out17(o[17]), .out18(o[18]), .out19(o[19]), .out20(o[20]), .out21(o[21]), .out22(o[22]), .out23(o[23]),
        .out24(o[24]), .out25(o[25]), .out26(o[26]), .out27(o[27]), .out28(o[28]), .out29(o[29]), .out30(o[30]), .out31(o[31]),
        .out32(o[32]), .out33(o[33]), .out34(o[34]), .out35(o[35]), .out36(o[36]), .out37(o[37]), .out38(o[38]), .out39(o[39]),
        .out40(o[40]), .out41(o[41]), .out42(o[42]), .out43(o[43]), .out44(o[44]), .out45(o[45]), .out46(o[46]), .out47(o[47]),
        .out48(o[48]), .out49(o[49]), .out50(o[50]), .out51(o[51]), .out52(o[52]), .out53(o[53]), .out54(o[54]), .out55(o[55]),
        .out56(o[56]), .out57(o[57]), .out58(o[58]), .out59(o[59]), .out60(o[60]), .out61(o[61]), .out62(o[62]), .out63(o[63])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_block(input string tag, input int v);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("%s[%0d]", tag, i), o[i], v);
        end
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int nz;
        for (int c = 0; c < cycles; c++) begin
            tick(1);
            nz = 0;
            for (int i = 0; i < 64; i++) begin
                if (o[i] !== 16'sd0) nz++;
            end
            check($sformatf("%s_nonzero@%0d", tag, c), nz, 0);
        end
    endtask

    task automatic set_dc(input int v);
        for (int i = 0; i < 64; i++) x[i] = '0;
        x[0] = 16'(v);
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 64; i++) x[i] = 16'(-i);
    endtask

    task automatic check_ramp(input string tag);
        check({tag, "_out0"}, o[0], -173);
        check({tag, "_out1"}, o[1], 63);
        check({tag, "_out8"}, o[8], 176);
        check({tag, "_out63"}, o[63], 0);
    endtask

    initial begin
        // Reset with random coefficients on the inputs.
        rst = 1'b1;
        for (int e = 0; e < 3; e++) begin
            for (int i = 0; i < 64; i++) x[i] = 16'($urandom);
            tick(1);
        end
        check_block("reset", 0);
        rst = 1'b0;
        set_dc(0);
        idle_check("idle", 40);

        // DC block: 64 -> every pixel 8, exactly 28 edges after the sampling edge.
        set_dc(64);
        tick(28);
        check("dc_early_out0", o[0], 0);
        tick(1);
        check_block("dc", 8);

        set_ramp();
        tick(28);
        check("ramp_early_out0", o[0], 8);
        tick(1);
        check_ramp("ramp");

        set_dc(2047);
        tick(29);
        check_block("clip_hi", 255);

        set_dc(-4000);
        tick(28);
        check("clip_lo_early_out0", o[0], 255);
        tick(1);
        check_block("clip_lo", -256);

        // Back-to-back blocks on consecutive edges.
        set_dc(64);
        tick(1);
        set_ramp();
        tick(1);
        set_dc(2047);
        tick(1);
        set_dc(0);
        tick(25);
        check("stream_early_out0", o[0], -256);
        tick(1);
        check_block("stream_dc", 8);
        tick(1);
        check_ramp("stream_ramp");
        tick(1);
        check_block("stream_clip", 255);
        tick(1);
        check_block("stream_zero", 0);

        // Reset while a full pipeline of clipping blocks is in flight.
        set_dc(2047);
        tick(35);
        check("pre_rst_out0", o[0], 255);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        set_dc(0);
        check_block("mid_rst", 0);
        idle_check("post_rst", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
